// File: rtl/launch_actuator_pkg.sv
// Shared types and default 50 MHz timing constants for the launch actuator.
package launch_actuator_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StTrigger,
      StCooldown
   } state_t;

   localparam int unsigned PWM_PERIOD = 1000000;
   localparam int unsigned SERVO_MIN  = 50000;
   localparam int unsigned SERVO_STEP = 278;
   localparam int unsigned ANGLE_MAX  = 180;

   localparam logic [7:0] VELOCITY_MAX = 8'd255;

endpackage

// File: rtl/launch_actuator_pwm_gen.sv
// Frame-based PWM generator: the duty is sampled only at frame start, output is registered.
module pwm_gen #(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned PERIOD = 256
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] duty,
   output logic             pwm
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             pwm_d;

   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
      // The count-0 cycle already compares against the freshly sampled duty.
      width_d = (count_q == '0) ? duty : width_q;
      pwm_d   = (count_q < width_d);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         width_q <= '0;
         pwm     <= 1'b0;
      end else begin
         count_q <= count_d;
         width_q <= width_d;
         pwm     <= pwm_d;
      end
   end

endmodule

// File: rtl/launch_actuator.sv
// Launcher drive: servo/motor PWM from the active setpoint and a settle-gated timed trigger.
module launch_actuator #(
   parameter int unsigned PWM_PERIOD      = launch_actuator_pkg::PWM_PERIOD,
   parameter int unsigned SERVO_MIN       = launch_actuator_pkg::SERVO_MIN,
   parameter int unsigned SERVO_STEP      = launch_actuator_pkg::SERVO_STEP,
   parameter int unsigned ANGLE_MAX       = launch_actuator_pkg::ANGLE_MAX,
   parameter int unsigned SETTLE_CYCLES   = 25000000,
   parameter int unsigned TRIGGER_CYCLES  = 10000000,
   parameter int unsigned COOLDOWN_CYCLES = 15000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] angle_in,
   input  logic [31:0] velocity_in,
   input  logic        fire_in,
   output logic        servo_pwm,
   output logic        motor_pwm,
   output logic        trigger_out,
   output logic        busy,
   output logic        settled,
   output logic [7:0]  fired_count
);

   import launch_actuator_pkg::*;

   state_t      state_q, state_d;
   logic [31:0] angle_q, angle_d, angle_clamped;
   logic [7:0]  vel_q, vel_d, vel_clamped;
   logic [31:0] timer_q, timer_d;
   logic [31:0] dur_q, dur_d;
   logic [7:0]  count_q, count_d;
   logic [31:0] servo_width;
   logic        setpoint_change;
   logic        trigger_done;
   logic        cooldown_done;

   // Setpoint loading and settle timer
   always_comb begin
      angle_clamped = (angle_in > ANGLE_MAX) ? ANGLE_MAX : angle_in;
      vel_clamped   = (velocity_in > 32'(VELOCITY_MAX)) ? VELOCITY_MAX : velocity_in[7:0];
      angle_d       = angle_q;
      vel_d         = vel_q;
      if (state_q == StIdle) begin
         angle_d = angle_clamped;
         vel_d   = vel_clamped;
      end
      setpoint_change = (angle_d != angle_q) || (vel_d != vel_q);
      if (setpoint_change) begin
         timer_d = '0;
      end else if (timer_q != SETTLE_CYCLES) begin
         timer_d = timer_q + 32'd1;
      end else begin
         timer_d = timer_q;
      end
      servo_width = SERVO_MIN + angle_q * SERVO_STEP;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         angle_q <= '0;
         vel_q   <= '0;
         timer_q <= '0;
         dur_q   <= '0;
         count_q <= '0;
      end else begin
         angle_q <= angle_d;
         vel_q   <= vel_d;
         timer_q <= timer_d;
         dur_q   <= dur_d;
         count_q <= count_d;
      end
   end

   // FSM: state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state, shared duration counter and shot counter
   always_comb begin
      trigger_done  = (state_q == StTrigger) && (dur_q == TRIGGER_CYCLES - 1);
      cooldown_done = (state_q == StCooldown) && (dur_q == COOLDOWN_CYCLES - 1);
      state_d       = state_q;
      unique case (state_q)
         StIdle:     if (fire_in) state_d = StArmed;
         StArmed:    if (settled) state_d = StTrigger;
         StTrigger:  if (trigger_done) state_d = StCooldown;
         StCooldown: if (cooldown_done) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
      if ((state_d != state_q) || (state_q == StIdle) || (state_q == StArmed)) begin
         dur_d = '0;
      end else begin
         dur_d = dur_q + 32'd1;
      end
      count_d = trigger_done ? count_q + 8'd1 : count_q;
   end

   // FSM: outputs
   always_comb begin
      trigger_out = (state_q == StTrigger);
      busy        = (state_q != StIdle);
      settled     = (timer_q == SETTLE_CYCLES);
      fired_count = count_q;
   end

   pwm_gen #(
      .CNT_W  (32),
      .PERIOD (PWM_PERIOD)
   ) u_servo_pwm (
      .clock (clock),
      .reset (reset),
      .duty  (servo_width),
      .pwm   (servo_pwm)
   );

   pwm_gen #(
      .CNT_W  (8),
      .PERIOD (256)
   ) u_motor_pwm (
      .clock (clock),
      .reset (reset),
      .duty  (vel_q),
      .pwm   (motor_pwm)
   );

endmodule
